// File: rtl/gamepad_mmio_if.sv
// Data-bus connection of the gamepad register window: word address, write data,
// strobes, registered read data and the combinational window hit.
interface gamepad_mmio_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic              wren;
  logic              rden;
  logic [31:0]       data_out;
  logic              hit;

  modport master (
    output address, data_in, wren, rden,
    input  data_out, hit
  );

  modport slave (
    input  address, data_in, wren, rden,
    output data_out, hit
  );
endinterface

// File: rtl/gamepad_mmio.sv
// Memory-mapped gamepad controller: sync + debounce of NUM_PLAYERS x BTN_W buttons,
// sticky press latches, output and irq-mask registers. GAMEPAD_RELEASE_EVT_EN adds release latches.
module gamepad_mmio #(
  parameter int              NUM_PLAYERS = 2,
  parameter int              BTN_W       = 16,
  parameter int              DB_CYCLES   = 16,
  parameter int              ACTIVE_LOW  = 1,
  parameter int              ADDR_W      = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 13'h1000,
  parameter int              OUT_W       = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PLAYERS*BTN_W-1:0] gpio,
  gamepad_mmio_if.slave                bus,
  output logic [OUT_W-1:0]             gpioOutput,
  output logic                         irq
);

  localparam int unsigned NP       = NUM_PLAYERS;
  localparam int unsigned NB       = NUM_PLAYERS * BTN_W;
  localparam int unsigned CW       = $clog2(DB_CYCLES);
  localparam int unsigned BASE     = 32'(BASE_ADDR);
  localparam int unsigned OFF_OUT  = 2 * NP;
  localparam int unsigned OFF_MASK = 2 * NP + 1;
  localparam logic [NB-1:0] RELEASED = (ACTIVE_LOW != 0) ? {NB{1'b1}} : {NB{1'b0}};

  logic [NB-1:0] sync1, sync2, synced;
  logic [NB-1:0] stable, stable_nxt, rise;
  logic [CW-1:0] cnt     [NB];
  logic [CW-1:0] cnt_nxt [NB];

  logic [NP-1:0][BTN_W-1:0] press, press_nxt;
`ifdef GAMEPAD_RELEASE_EVT_EN
  localparam int unsigned OFF_REL = 2 * NP + 2;
  logic [NB-1:0]            fall;
  logic [NP-1:0][BTN_W-1:0] rel, rel_nxt;
`endif

  logic [OUT_W-1:0] out_reg;
  logic [NP-1:0]    mask, pend;
  logic             irq_nxt;
  int unsigned      addr_u, off;
  logic             rd, wr;
  logic [31:0]      rdata;

  assign synced     = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  assign gpioOutput = out_reg;

  always_comb begin
    addr_u  = 32'(bus.address);
    off     = addr_u - BASE;
    bus.hit = (addr_u >= BASE) && (addr_u < BASE + 4 * NP);
    rd      = bus.rden & bus.hit;
    wr      = bus.wren & bus.hit;
  end

  // Counter runs only while synced disagrees with stable; commit on the
  // DB_CYCLES-th consecutive mismatch, so the counter can never wrap.
  always_comb begin
    stable_nxt = stable;
    for (int unsigned b = 0; b < NB; b++) begin
      cnt_nxt[b] = '0;
      if (synced[b] != stable[b]) begin
        if (cnt[b] == CW'(DB_CYCLES - 1)) stable_nxt[b] = synced[b];
        else                              cnt_nxt[b]    = cnt[b] + CW'(1);
      end
    end
    rise = stable_nxt & ~stable;
`ifdef GAMEPAD_RELEASE_EVT_EN
    fall = stable & ~stable_nxt;
`endif
  end

  // An edge arriving in the same cycle as the clearing read is kept (set wins).
  always_comb begin
    rdata     = '0;
    press_nxt = press;
    pend      = '0;
`ifdef GAMEPAD_RELEASE_EVT_EN
    rel_nxt   = rel;
`endif
    for (int unsigned p = 0; p < NP; p++) begin
      if (off == p)      rdata[BTN_W-1:0] = stable[p*BTN_W +: BTN_W];
      if (off == NP + p) rdata[BTN_W-1:0] = press[p];
      press_nxt[p] = rise[p*BTN_W +: BTN_W] | ((rd && off == NP + p) ? '0 : press[p]);
      pend[p]      = |press[p];
`ifdef GAMEPAD_RELEASE_EVT_EN
      if (off == OFF_REL + p) rdata[BTN_W-1:0] = rel[p];
      rel_nxt[p] = fall[p*BTN_W +: BTN_W] | ((rd && off == OFF_REL + p) ? '0 : rel[p]);
      pend[p]    = pend[p] | (|rel[p]);
`endif
    end
    if (off == OFF_OUT)  rdata[OUT_W-1:0] = out_reg;
    if (off == OFF_MASK) rdata[NP-1:0]    = mask;
    irq_nxt = |(pend & mask);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1        <= RELEASED;
      sync2        <= RELEASED;
      stable       <= '0;
      cnt          <= '{default: '0};
      press        <= '0;
`ifdef GAMEPAD_RELEASE_EVT_EN
      rel          <= '0;
`endif
      out_reg      <= '0;
      mask         <= '0;
      bus.data_out <= '0;
      irq          <= 1'b0;
    end else begin
      sync1  <= gpio;
      sync2  <= sync1;
      stable <= stable_nxt;
      cnt    <= cnt_nxt;
      press  <= press_nxt;
`ifdef GAMEPAD_RELEASE_EVT_EN
      rel    <= rel_nxt;
`endif
      if (rd) bus.data_out <= rdata;
      if (wr && off == OFF_OUT)  out_reg <= bus.data_in[OUT_W-1:0];
      if (wr && off == OFF_MASK) mask    <= bus.data_in[NP-1:0];
      irq <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_gamepad_mmio.sv
// Bench for gamepad_mmio: directed scenarios plus randomized gpio/bus traffic,
// every cycle compared against a behavioural register-map model.
module tb_gamepad_mmio;

  localparam int NP   = 2;
  localparam int BW   = 16;
  localparam int DB   = 16;
  localparam int NB   = NP * BW;
  localparam int BASE = 'h1000;

  logic          clock;
  logic          reset;
  logic [NB-1:0] gpio;
  logic [2:0]    gpioOutput;
  logic          irq;

  int checks = 0;
  int errors = 0;

  gamepad_mmio_if #(.ADDR_W(13)) bus ();

  gamepad_mmio #(
    .NUM_PLAYERS(NP), .BTN_W(BW), .DB_CYCLES(DB), .ACTIVE_LOW(1),
    .ADDR_W(13), .BASE_ADDR(13'h1000), .OUT_W(3)
  ) dut (
    .clock(clock), .reset(reset), .gpio(gpio), .bus(bus),
    .gpioOutput(gpioOutput), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: raw lines pass a 2-stage delay, a button's level is accepted
  // once it has disagreed with the accepted level for DB consecutive cycles.
  logic [NB-1:0] m_d1, m_d2, m_stable;
  int            m_run [NB];
  logic [BW-1:0] m_press [NP];
  logic [BW-1:0] m_rel   [NP];
  logic [2:0]    m_out;
  logic [1:0]    m_mask;
  logic [31:0]   m_dout;
  logic          m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int off);
    logic [31:0] v = '0;
    if (off >= 0 && off < NP)            v = 32'(m_stable[off*BW +: BW]);
    else if (off >= NP && off < 2*NP)    v = 32'(m_press[off-NP]);
    else if (off == 2*NP)                v = 32'(m_out);
    else if (off == 2*NP + 1)            v = 32'(m_mask);
`ifdef GAMEPAD_RELEASE_EVT_EN
    else if (off >= 2*NP+2 && off < 3*NP+2) v = 32'(m_rel[off-2*NP-2]);
`endif
    return v;
  endfunction

  function automatic bit m_hit(input int off);
    return off >= 0 && off < 4*NP;
  endfunction

  task automatic model_edge();
    int          off = int'(bus.address) - BASE;
    bit          h   = m_hit(off);
    logic [31:0] rv  = m_read(off);
    logic [NB-1:0] seen = ~m_d2;
    logic [NB-1:0] rise = '0, fall = '0;
    bit          irq_n = 0;
    if (reset) begin
      m_d1 = '1; m_d2 = '1; m_stable = '0;
      foreach (m_run[b]) m_run[b] = 0;
      for (int p = 0; p < NP; p++) begin m_press[p] = '0; m_rel[p] = '0; end
      m_out = '0; m_mask = '0; m_dout = '0; m_irq = 0;
      return;
    end
    for (int p = 0; p < NP; p++) begin
      bit pend = (m_press[p] != 0);
`ifdef GAMEPAD_RELEASE_EVT_EN
      pend = pend || (m_rel[p] != 0);
`endif
      if (pend && m_mask[p]) irq_n = 1;
    end
    for (int b = 0; b < NB; b++) begin
      if (seen[b] == m_stable[b]) m_run[b] = 0;
      else if (m_run[b] + 1 == DB) begin
        if (seen[b]) rise[b] = 1'b1; else fall[b] = 1'b1;
        m_stable[b] = seen[b];
        m_run[b] = 0;
      end else m_run[b] = m_run[b] + 1;
    end
    for (int p = 0; p < NP; p++) begin
      if (bus.rden && h && off == NP + p) m_press[p] = '0;
      m_press[p] = m_press[p] | rise[p*BW +: BW];
`ifdef GAMEPAD_RELEASE_EVT_EN
      if (bus.rden && h && off == 2*NP + 2 + p) m_rel[p] = '0;
      m_rel[p] = m_rel[p] | fall[p*BW +: BW];
`endif
    end
    if (bus.rden && h) m_dout = rv;
    if (bus.wren && h && off == 2*NP)     m_out  = bus.data_in[2:0];
    if (bus.wren && h && off == 2*NP + 1) m_mask = bus.data_in[1:0];
    m_irq = irq_n;
    m_d2 = m_d1;
    m_d1 = gpio;
  endtask

  task automatic tick();
    int off;
    @(posedge clock);
    model_edge();
    #1;
    off = int'(bus.address) - BASE;
    chk("data_out",   bus.data_out,     m_dout);
    chk("irq",        32'(irq),         32'(m_irq));
    chk("gpioOutput", 32'(gpioOutput),  32'(m_out));
    chk("hit",        32'(bus.hit),     32'(m_hit(off)));
  endtask

  task automatic rd(input int off);
    bus.rden = 1'b1; bus.wren = 1'b0; bus.address = 13'(BASE + off);
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    bus.rden = 1'b0; bus.wren = 1'b1; bus.address = 13'(BASE + off); bus.data_in = d;
  endtask

  task automatic idle();
    bus.rden = 1'b0; bus.wren = 1'b0;
  endtask

  initial begin
    reset = 1'b1; gpio = '1;
    bus.address = 13'(BASE); bus.data_in = '0; bus.wren = 1'b0; bus.rden = 1'b0;
    repeat (3) tick();
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_gpioOutput", 32'(gpioOutput), 32'h0);
    reset = 1'b0;

    rd(0); tick(); chk("state0_idle", bus.data_out, 32'h0);
    rd(1); tick(); chk("state1_idle", bus.data_out, 32'h0);

    // single press: STATE flips exactly DB+2 edges after the first sampling edge
    rd(0); gpio[0] = 1'b0;
    repeat (DB + 2) tick();
    chk("state0_before", bus.data_out, 32'h0);
    tick();
    chk("state0_after", bus.data_out, 32'h1);
    rd(NP); tick(); chk("press0_first", bus.data_out, 32'h1);
    tick();         chk("press0_second", bus.data_out, 32'h0);

    // short glitch must be rejected
    idle(); gpio[17] = 1'b0;
    repeat (10) tick();
    gpio[17] = 1'b1;
    repeat (DB + 6) tick();
    rd(1);      tick(); chk("glitch_state1", bus.data_out, 32'h0);
    rd(NP + 1); tick(); chk("glitch_press1", bus.data_out, 32'h0);

    // irq for player 1
    wr(2*NP + 1, 32'h2); tick();
    idle(); gpio[19] = 1'b0;
    repeat (DB + 2) tick();
    chk("irq_not_yet", 32'(irq), 32'h0);
    tick();
    chk("irq_set", 32'(irq), 32'h1);
    rd(NP + 1); tick(); chk("press1_btn3", bus.data_out, 32'h8);
    idle(); tick(); chk("irq_cleared", 32'(irq), 32'h0);

    // new edge coincident with clearing read survives
    gpio[1] = 1'b0;
    repeat (DB + 1) tick();
    rd(NP); tick(); chk("press0_coincident", bus.data_out, 32'h0);
    tick();         chk("press0_survived", bus.data_out, 32'h2);
    tick();         chk("press0_cleared", bus.data_out, 32'h0);

    wr(2*NP, 32'h5); tick(); idle();
    chk("gpioOutput_5", 32'(gpioOutput), 32'h5);
    bus.rden = 1'b1; bus.wren = 1'b1; bus.data_in = 32'h3; bus.address = 13'(BASE + 2*NP);
    tick(); chk("rw_same_cycle", bus.data_out, 32'h5);
    chk("gpioOutput_3", 32'(gpioOutput), 32'h3);
    wr(2*NP, 32'hFFFF_FFFE); tick();
    rd(2*NP); tick(); chk("out_upper_zero", bus.data_out, 32'h6);
    bus.address = 13'(BASE - 1); tick(); chk("miss_holds", bus.data_out, 32'h6);

`ifdef GAMEPAD_RELEASE_EVT_EN
    idle(); gpio[0] = 1'b1;
    repeat (DB + 3) tick();
    rd(2*NP + 2); tick(); chk("release0", bus.data_out, 32'h1);
    idle();
`endif

    // reset in the middle of a debounce window
    idle(); gpio[2] = 1'b0;
    repeat (8) tick();
    reset = 1'b1; gpio = '1; tick(); reset = 1'b0;
    repeat (DB + 4) tick();
    for (int o = 0; o < 4*NP; o++) begin
      rd(o); tick(); chk("post_reset_reg", bus.data_out, 32'h0);
    end
    chk("post_reset_irq", 32'(irq), 32'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0)
        gpio[$urandom_range(0, 3) + BW * $urandom_range(0, 1)] ^= 1'b1;
      bus.rden    = ($urandom_range(0, 2) == 0);
      bus.wren    = ($urandom_range(0, 4) == 0);
      bus.address = 13'(BASE - 2 + $urandom_range(0, 4*NP + 3));
      bus.data_in = $urandom;
      reset       = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0; idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
